// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_stage_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC        = 32'h0000_0000;
  localparam logic [31:0] NOP_INST        = 32'h0000_0000;
  localparam logic [15:0] FETCH_COUNT_MAX = 16'hFFFF;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset > flush (bubble, pc kept) > hold > load.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = if_stage_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  input  logic        load_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      inst  <= NOP_INST;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      inst  <= NOP_INST;
      valid <= 1'b0;
    end else if (!hold) begin
      inst  <= load_inst;
      pc    <= load_pc;
      valid <= load_valid;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage for a synchronous-read instruction memory,
// with stall, redirect and a saturating delivered-instruction counter.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = if_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = if_stage_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_IF,
  output logic [31:0] pc_ID,
  output logic [31:0] inst_ID,
  output logic        valid_ID,
  output logic [15:0] fetch_count
);

  logic [31:0]  pc_q;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  hold_inst_q;
  logic [15:0]  fetch_count_q;
  fetch_state_t state_q;

  logic [31:0]  next_inst;
  logic         next_valid;

  // While stalled the memory keeps reading pc, so the in-flight word is
  // only recoverable from hold_inst once the stall began in RUN.
  always_comb begin
    next_inst  = (state_q == HOLD) ? hold_inst_q : inst;
    next_valid = (state_q != FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
      hold_inst_q   <= '0;
      fetch_count_q <= '0;
      state_q       <= FILL;
    end else if (redirect) begin
      pc_q    <= align_word(redirect_pc);
      state_q <= FILL;
    end else if (stall) begin
      if (state_q == RUN) begin
        hold_inst_q <= inst;
        state_q     <= HOLD;
      end
    end else begin
      fetch_pc_q <= pc_q;
      pc_q       <= pc_q + 32'd4;
      state_q    <= RUN;
      if (next_valid && fetch_count_q != FETCH_COUNT_MAX)
        fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .hold      (stall),
    .load_inst (next_inst),
    .load_pc   (fetch_pc_q),
    .load_valid(next_valid),
    .inst      (inst_ID),
    .pc        (pc_ID),
    .valid     (valid_ID)
  );

  assign inst_addr   = pc_q;
  assign pc_IF       = pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h00000000, meaning instruction word driven on bubbles.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-005 SHALL have port inst_addr, output, 32, meaning address to instmem, driven directly from the PC register.
REQ-006 SHALL have port inst, input, 32, meaning instmem read data, equal to mem[inst_addr sampled at the previous rising edge].
REQ-007 SHALL have port stall, input, 1, meaning hold the PC and IF/ID contents this edge.
REQ-008 SHALL have port redirect, input, 1, meaning branch/jump taken: flush and refetch.
REQ-009 SHALL have port redirect_pc, input, 32, meaning target address; bits [1:0] ignored and forced to 0.
REQ-010 SHALL have port pc_IF, output, 32, meaning current PC (same value as inst_addr).
REQ-011 SHALL have port pc_ID, output, 32, meaning address of the instruction in IF/ID.
REQ-012 SHALL have port inst_ID, output, 32, meaning the IF/ID instruction word.
REQ-013 SHALL have port valid_ID, output, 1, meaning inst_ID is a real fetched instruction, not a bubble.
REQ-014 SHALL have port fetch_count, output, 16, meaning saturating count of valid instructions delivered to ID.

Function
REQ-015 SHALL hold registers pc, fetch_pc (address of the in-flight read), hold_inst, state, and IF/ID {inst_ID, pc_ID, valid_ID}.
REQ-016 SHALL implement FSM states FILL (nothing in flight), RUN (read in flight, inst live), HOLD (stalled, in-flight word captured in hold_inst).
REQ-017 Priority at each edge SHALL be rst > redirect > stall > normal.
REQ-018 Redirect, any state: pc<=redirect_pc&~3; IF/ID<=bubble (NOP_INST, valid_ID=0, pc_ID unchanged); state<=FILL.
REQ-019 Stall in FILL: all registers hold; state stays FILL.
REQ-020 Stall in RUN: hold_inst<=inst; pc and IF/ID hold; state<=HOLD.
REQ-021 Stall in HOLD: all registers hold; state stays HOLD.
REQ-022 Normal edge: IF/ID<={HOLD?hold_inst:inst, fetch_pc, state!=FILL}; fetch_pc<=pc; pc<=pc+4; state<=RUN.
REQ-023 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-024 Steady-state latency SHALL be 2 edges from address on inst_addr to the word on inst_ID; redirect penalty SHALL be exactly 2 bubbles.
REQ-025 fetch_count SHALL increment on every edge that loads valid_ID=1 into IF/ID and SHALL saturate at 16'hFFFF.
REQ-026 Outputs SHALL have no combinational path from stall, redirect or inst.

Reset
REQ-027 On rst edge: pc=RESET_PC, fetch_pc=RESET_PC, state=FILL, inst_ID=NOP_INST, pc_ID=0, valid_ID=0, hold_inst=0, fetch_count=0.
REQ-028 rst asserted mid-stall or mid-redirect SHALL discard all in-flight and held state.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration and the constants NOP_INST and RESET_PC.
REQ-030 One sub-module, if_id_reg (IF/ID pipeline register with hold/flush controls), SHALL be instantiated.

Verification
REQ-031 Reset, then 4 free-running cycles with mem[i]=i -> inst_addr 0,4,8,12; inst_ID 0,4 starting edge 2; valid_ID 0,0,1,1.
REQ-032 Stall high 3 cycles while RUN with fetch_pc=8 -> after release, inst_ID=mem[8] then mem[12]; no word lost or duplicated.
REQ-033 Redirect to 32'h00000103 with stall also high -> inst_addr=32'h00000100 next cycle; 2 bubbles; then inst_ID=mem[0x100].
REQ-034 Set pc to 32'hFFFFFFFC via redirect -> following inst_addr=32'h00000000.
REQ-035 rst pulsed during HOLD -> next cycle inst_addr=RESET_PC, valid_ID=0, fetch_count=0.
REQ-036 Force fetch_count to 16'hFFFE, deliver 3 valid instructions -> fetch_count=16'hFFFF.
